// File: rtl/int_to_float.sv
// Pipelined integer to packed-float converter: abs, leading-zero count, normalise/pack.
// Three clocks from a sampled request to a registered result, one conversion per cycle.
module int_to_float #(
  parameter int INT_SIZE      = 32,
  parameter int MANTISSA_SIZE = 23,
  parameter int EXPONENT_SIZE = 8,
  localparam int FLOAT_SIZE   = 1 + EXPONENT_SIZE + MANTISSA_SIZE
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [INT_SIZE-1:0]   intIn,
  input  logic                  signedIn,
  input  logic                  validIn,
  output logic [FLOAT_SIZE-1:0] floatOut,
  output logic                  validOut
);

  localparam int LZ_W  = $clog2(INT_SIZE + 1);
  localparam int EXP_W = EXPONENT_SIZE + 2;
  localparam logic [EXP_W-1:0] BIAS    = EXP_W'((1 << (EXPONENT_SIZE - 1)) - 1);
  localparam logic [EXP_W-1:0] EXP_INF = EXP_W'((1 << EXPONENT_SIZE) - 1);

  // Stage 1: sign and magnitude
  logic                sign_in;
  logic [INT_SIZE-1:0] mag_in;
  logic                s1_valid;
  logic                s1_sign;
  logic [INT_SIZE-1:0] s1_mag;

  assign sign_in = signedIn & intIn[INT_SIZE-1];
  // The most negative value negates to itself, which reads correctly as an unsigned magnitude.
  assign mag_in  = sign_in ? -intIn : intIn;

  // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_mag   <= '0;
    end else begin
      s1_valid <= validIn;
      s1_sign  <= sign_in;
      s1_mag   <= mag_in;
    end
  end

  // Stage 2: leading-zero count and biased exponent
  logic [LZ_W-1:0]     lz;
  logic [EXP_W-1:0]    exp_next;
  logic                s2_valid;
  logic                s2_sign;
  logic                s2_zero;
  logic [LZ_W-1:0]     s2_lz;
  logic [EXP_W-1:0]    s2_exp;
  logic [INT_SIZE-1:0] s2_mag;

  // NOTE: lz is given a default before the loop so the block can never infer a latch.
  always_comb begin
    lz = LZ_W'(INT_SIZE);
    for (int i = 0; i < INT_SIZE; i++) begin
      if (s1_mag[i]) lz = LZ_W'(INT_SIZE - 1 - i);
    end
  end

  assign exp_next = BIAS + EXP_W'(INT_SIZE - 1) - EXP_W'(lz);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s2_valid <= 1'b0;
      s2_sign  <= 1'b0;
      s2_zero  <= 1'b0;
      s2_lz    <= '0;
      s2_exp   <= '0;
      s2_mag   <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_sign  <= s1_sign;
      s2_zero  <= (s1_mag == '0);
      s2_lz    <= lz;
      s2_exp   <= exp_next;
      s2_mag   <= s1_mag;
    end
  end

  // Stage 3: normalise, truncate, pack
  logic [MANTISSA_SIZE-1:0] mant;
  logic [FLOAT_SIZE-1:0]    packed_float;
  logic                     s3_valid;
  logic [FLOAT_SIZE-1:0]    s3_float;

  // Shifting one past the leading one drops the hidden bit; zero padding covers narrow integers.
  assign mant = MANTISSA_SIZE'(({s2_mag, {MANTISSA_SIZE{1'b0}}} << (32'(s2_lz) + 32'd1)) >> INT_SIZE);

  always_comb begin
    if (s2_zero)
      packed_float = '0;
    else if (s2_exp >= EXP_INF)
      packed_float = {s2_sign, EXP_INF[EXPONENT_SIZE-1:0], {MANTISSA_SIZE{1'b0}}};
    else
      packed_float = {s2_sign, s2_exp[EXPONENT_SIZE-1:0], mant};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s3_valid <= 1'b0;
      s3_float <= '0;
    end else begin
      s3_valid <= s2_valid;
      s3_float <= packed_float;
    end
  end

  // Output register holds the last result across bubbles
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      validOut <= 1'b0;
      floatOut <= '0;
    end else begin
      validOut <= s3_valid;
      if (s3_valid) floatOut <= s3_float;
    end
  end

endmodule
